// File: rtl/layer_mixer.sv
// Fixed-priority layer compositor (me > bullet > enemy > bg) with per-pixel collision
// detection and per-frame collision accumulation into frame-end pulses and a hit counter.
module layer_mixer #(
    parameter int unsigned H_DISP    = 640,
    parameter int unsigned V_DISP    = 480,
    parameter int unsigned HIT_CNT_W = 16,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9,
    parameter int unsigned RGB_W     = 12
) (
    input  logic                 clk_vga,
    input  logic                 rst,
    input  logic [X_W-1:0]       req_x_addr_i,
    input  logic [Y_W-1:0]       req_y_addr_i,
    input  logic                 disp_en_i,
    input  logic                 game_run_i,
    input  logic                 clr_score_i,
    input  logic [RGB_W-1:0]     bg_rgb_i,
    input  logic [RGB_W-1:0]     me_rgb_i,
    input  logic                 me_alpha_i,
    input  logic [RGB_W-1:0]     enemy_rgb_i,
    input  logic                 enemy_alpha_i,
    input  logic [RGB_W-1:0]     bullet_rgb_i,
    input  logic                 bullet_alpha_i,
    output logic [RGB_W-1:0]     vga_rgb_o,
    output logic                 crash_enemy_bullet_o,
    output logic                 frame_end_o,
    output logic                 frame_crash_me_o,
    output logic [HIT_CNT_W-1:0] hit_cnt_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_DISP - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_DISP - 1);

    logic             acc_hit;
    logic             acc_me;
    logic             me_overlap;
    logic             frame_last;
    logic [RGB_W-1:0] mix_rgb;

    assign crash_enemy_bullet_o = enemy_alpha_i & bullet_alpha_i & disp_en_i & game_run_i;
    assign me_overlap           = me_alpha_i & enemy_alpha_i & disp_en_i & game_run_i;
    assign frame_last = disp_en_i && (req_x_addr_i == X_LAST) && (req_y_addr_i == Y_LAST);

    always_comb begin
        mix_rgb = '0;
        if (disp_en_i) begin
            if (me_alpha_i)          mix_rgb = me_rgb_i;
            else if (bullet_alpha_i) mix_rgb = bullet_rgb_i;
            else if (enemy_alpha_i)  mix_rgb = enemy_rgb_i;
            else                     mix_rgb = bg_rgb_i;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            vga_rgb_o        <= '0;
            frame_end_o      <= 1'b0;
            frame_crash_me_o <= 1'b0;
            hit_cnt_o        <= '0;
            acc_hit          <= 1'b0;
            acc_me           <= 1'b0;
        end else begin
            vga_rgb_o        <= mix_rgb;
            frame_end_o      <= frame_last;
            // Overlap on the last pixel belongs to the frame that is ending.
            frame_crash_me_o <= frame_last & (acc_me | me_overlap);

            if (!game_run_i || frame_last) begin
                acc_hit <= 1'b0;
                acc_me  <= 1'b0;
            end else begin
                if (crash_enemy_bullet_o) acc_hit <= 1'b1;
                if (me_overlap)           acc_me  <= 1'b1;
            end

            if (clr_score_i) begin
                hit_cnt_o <= '0;
            end else if (frame_last && (acc_hit || crash_enemy_bullet_o) && !(&hit_cnt_o)) begin
                hit_cnt_o <= hit_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer: priority mixing, collision flags,
// frame-end pulses, hit counter saturation/clear, game masking and mid-frame reset.
module tb_layer_mixer;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de, run, clr;
    logic [11:0] bg_rgb, me_rgb, enemy_rgb, bullet_rgb;
    logic        me_a, enemy_a, bullet_a;
    logic [11:0] vga_rgb;
    logic        crash, frame_end, frame_crash_me;
    logic [1:0]  hit_cnt;

    int cmps = 0;
    int errs = 0;

    layer_mixer #(
        .H_DISP(640), .V_DISP(480), .HIT_CNT_W(2), .X_W(10), .Y_W(9), .RGB_W(12)
    ) dut (
        .clk_vga(clk_vga), .rst(rst),
        .req_x_addr_i(x), .req_y_addr_i(y), .disp_en_i(de),
        .game_run_i(run), .clr_score_i(clr),
        .bg_rgb_i(bg_rgb),
        .me_rgb_i(me_rgb), .me_alpha_i(me_a),
        .enemy_rgb_i(enemy_rgb), .enemy_alpha_i(enemy_a),
        .bullet_rgb_i(bullet_rgb), .bullet_alpha_i(bullet_a),
        .vga_rgb_o(vga_rgb), .crash_enemy_bullet_o(crash),
        .frame_end_o(frame_end), .frame_crash_me_o(frame_crash_me),
        .hit_cnt_o(hit_cnt)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic pix(input int px, input int py, input logic d,
                       input logic m, input logic e, input logic b);
        x = 10'(px); y = 9'(py); de = d; me_a = m; enemy_a = e; bullet_a = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; clr = 1'b0;
        bg_rgb = 12'h888; me_rgb = 12'hF00; bullet_rgb = 12'h0F0; enemy_rgb = 12'h00F;
        pix(1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); tick();
        cmps++; if (vga_rgb !== 12'h000) begin errs++; $display("FAIL reset_rgb got %h want 000", vga_rgb); end
        cmps++; if (frame_end !== 1'b0) begin errs++; $display("FAIL reset_fe got %b want 0", frame_end); end
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL reset_fcm got %b want 0", frame_crash_me); end
        cmps++; if (hit_cnt !== 2'd0) begin errs++; $display("FAIL reset_hit got %0d want 0", hit_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_priority();
        run = 1'b0;
        pix(10, 10, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        cmps++; if (vga_rgb !== 12'hF00) begin errs++; $display("FAIL prio_me got %h want F00", vga_rgb); end
        pix(11, 10, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        cmps++; if (vga_rgb !== 12'h0F0) begin errs++; $display("FAIL prio_bullet got %h want 0F0", vga_rgb); end
        pix(12, 10, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        cmps++; if (vga_rgb !== 12'h00F) begin errs++; $display("FAIL prio_enemy got %h want 00F", vga_rgb); end
        pix(13, 10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (vga_rgb !== 12'h888) begin errs++; $display("FAIL prio_bg got %h want 888", vga_rgb); end
        pix(14, 10, 1'b0, 1'b1, 1'b1, 1'b1); tick();
        cmps++; if (vga_rgb !== 12'h000) begin errs++; $display("FAIL prio_blank got %h want 000", vga_rgb); end
        cmps++; if (frame_end !== 1'b0) begin errs++; $display("FAIL prio_fe got %b want 0", frame_end); end
    endtask

    task automatic test_hit();
        run = 1'b1;
        pix(100, 50, 1'b1, 1'b0, 1'b1, 1'b1);
        cmps++; if (crash !== 1'b1) begin errs++; $display("FAIL hit_comb got %b want 1", crash); end
        tick();
        pix(101, 50, 1'b1, 1'b0, 1'b1, 1'b0);
        cmps++; if (crash !== 1'b0) begin errs++; $display("FAIL hit_comb_off got %b want 0", crash); end
        for (int i = 0; i < 20; i++) begin
            pix(200 + i, 60, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        end
        pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (frame_end !== 1'b1) begin errs++; $display("FAIL hit_fe got %b want 1", frame_end); end
        cmps++; if (hit_cnt !== 2'd1) begin errs++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL hit_fcm got %b want 0", frame_crash_me); end
        pix(0, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (frame_end !== 1'b0) begin errs++; $display("FAIL hit_fe_1cyc got %b want 0", frame_end); end
        // Overlap outside the visible area must not register as a hit.
        pix(639, 479, 1'b0, 1'b1, 1'b1, 1'b1);
        cmps++; if (crash !== 1'b0) begin errs++; $display("FAIL blank_comb got %b want 0", crash); end
        tick();
        pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (hit_cnt !== 2'd1) begin errs++; $display("FAIL blank_hit got %0d want 1", hit_cnt); end
    endtask

    task automatic test_me_last();
        pix(639, 479, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        cmps++; if (frame_crash_me !== 1'b1) begin errs++; $display("FAIL me_fcm got %b want 1", frame_crash_me); end
        cmps++; if (frame_end !== 1'b1) begin errs++; $display("FAIL me_fe got %b want 1", frame_end); end
        cmps++; if (hit_cnt !== 2'd1) begin errs++; $display("FAIL me_hit got %0d want 1", hit_cnt); end
        pix(3, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL me_fcm_1cyc got %b want 0", frame_crash_me); end
        pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL me_next_fcm got %b want 0", frame_crash_me); end
        cmps++; if (frame_end !== 1'b1) begin errs++; $display("FAIL me_next_fe got %b want 1", frame_end); end
    endtask

    task automatic test_saturate();
        logic [1:0] want [3];
        want[0] = 2'd2; want[1] = 2'd3; want[2] = 2'd3;
        for (int f = 0; f < 3; f++) begin
            pix(5, 5, 1'b1, 1'b0, 1'b1, 1'b1); tick();
            pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0); tick();
            cmps++;
            if (hit_cnt !== want[f]) begin
                errs++; $display("FAIL sat_frame%0d got %0d want %0d", f, hit_cnt, want[f]);
            end
        end
        pix(5, 5, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        clr = 1'b1;
        pix(639, 479, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        clr = 1'b0;
        cmps++; if (hit_cnt !== 2'd0) begin errs++; $display("FAIL clr_hit got %0d want 0", hit_cnt); end
        pix(639, 479, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        cmps++; if (hit_cnt !== 2'd1) begin errs++; $display("FAIL last_pix_hit got %0d want 1", hit_cnt); end
    endtask

    task automatic test_game_off();
        run = 1'b0;
        pix(50, 50, 1'b1, 1'b1, 1'b1, 1'b1);
        cmps++; if (crash !== 1'b0) begin errs++; $display("FAIL off_comb got %b want 0", crash); end
        for (int i = 0; i < 5; i++) begin
            pix(50 + i, 50, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        end
        pix(639, 479, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        cmps++; if (frame_end !== 1'b1) begin errs++; $display("FAIL off_fe got %b want 1", frame_end); end
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL off_fcm got %b want 0", frame_crash_me); end
        cmps++; if (hit_cnt !== 2'd1) begin errs++; $display("FAIL off_hit got %0d want 1", hit_cnt); end
        run = 1'b1;
    endtask

    task automatic test_reset_mid();
        pix(60, 60, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        rst = 1'b1;
        pix(61, 60, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b0;
        cmps++; if (vga_rgb !== 12'h000) begin errs++; $display("FAIL rmid_rgb got %h want 000", vga_rgb); end
        cmps++; if (hit_cnt !== 2'd0) begin errs++; $display("FAIL rmid_hit got %0d want 0", hit_cnt); end
        cmps++; if (frame_end !== 1'b0) begin errs++; $display("FAIL rmid_fe got %b want 0", frame_end); end
        pix(639, 479, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        cmps++; if (frame_end !== 1'b1) begin errs++; $display("FAIL rmid_next_fe got %b want 1", frame_end); end
        cmps++; if (frame_crash_me !== 1'b0) begin errs++; $display("FAIL rmid_next_fcm got %b want 0", frame_crash_me); end
        cmps++; if (hit_cnt !== 2'd0) begin errs++; $display("FAIL rmid_next_hit got %0d want 0", hit_cnt); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hit();
        test_me_last();
        test_saturate();
        test_game_off();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
